// File: rtl/signal_pkg.sv
// ============================================================================
//  Module   : signal_pkg
//  Purpose  : Shared constants and types for the signal head driver: lamp bit
//             positions, fault cause codes, controller state encoding and a
//             one-hot helper for lamp codes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package signal_pkg;

    // Bit positions inside a 3-bit lamp code {red, amber, green}
    localparam int RED   = 2;
    localparam int AMBER = 1;
    localparam int GREEN = 0;

    // Fault cause codes reported on fault_code
    localparam logic [1:0] F_NONE     = 2'd0;
    localparam logic [1:0] F_CONFLICT = 2'd1;
    localparam logic [1:0] F_BADCODE  = 2'd2;
    localparam logic [1:0] F_WDOG     = 2'd3;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    // A legal lamp code has exactly one lamp lit
    function automatic logic is_one_hot(input logic [2:0] code);
        return (code != 3'b000) && ((code & (code - 3'b001)) == 3'b000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/signal_head_driver_if.sv
// ============================================================================
//  Module   : signal_head_driver_if
//  Purpose  : Bundles the controller stream, operator acknowledge and the
//             per-road lamp drives. master = controller/operator side,
//             slave = signal head driver.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface signal_head_driver_if #(
    parameter int ROADS = 4
);
    localparam int RW = (ROADS > 1) ? $clog2(ROADS) : 1;

    logic             light_valid;
    logic [RW-1:0]    road;
    logic [2:0]       light_out;
    logic             fault_clear;
    logic [ROADS-1:0] lamp_red;
    logic [ROADS-1:0] lamp_amber;
    logic [ROADS-1:0] lamp_green;
    logic             fault;
    logic [1:0]       fault_code;

    modport master (
        output light_valid, road, light_out, fault_clear,
        input  lamp_red, lamp_amber, lamp_green, fault, fault_code
    );

    modport slave (
        input  light_valid, road, light_out, fault_clear,
        output lamp_red, lamp_amber, lamp_green, fault, fault_code
    );

endinterface

`default_nettype wire

// File: rtl/signal_watchdog.sv
// ============================================================================
//  Module   : signal_watchdog
//  Purpose  : Counts enabled cycles since the last clear; raises timeout once
//             the count reaches WDOG_CYCLES. Held at zero while disabled.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module signal_watchdog #(
    parameter int WDOG_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic timeout
);
    localparam int CW = $clog2(WDOG_CYCLES + 1);
    localparam logic [CW-1:0] c_limit = CW'(WDOG_CYCLES);

    logic [CW-1:0] r_cnt;

    // Idle-cycle counter: restarts on every clear, frozen at zero when disabled
    always_ff @(posedge clk) begin
        if (!reset || !enable || clear) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign timeout = enable && (r_cnt == c_limit);

endmodule

`default_nettype wire

// File: rtl/signal_head_driver.sv
// ============================================================================
//  Module   : signal_head_driver
//  Purpose  : Holds one red/amber/green drive register per road, fed by the
//             traffic-light controller stream. Detects conflicting greens,
//             illegal lamp codes and a stalled controller, and forces a safe
//             lamp state until the operator clears the fault.
//  Config   : SIGNAL_HEAD_BLINK_EN - flashing amber in FAULT instead of steady
//             all red.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module signal_head_driver
    import signal_pkg::*;
#(
    parameter int ROADS       = 4,
    parameter int WDOG_CYCLES = 64,
    parameter int BLINK_HALF  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    signal_head_driver_if.slave  bus
);
    state_t           r_state, w_state_nxt;
    logic [1:0]       r_code, w_code_nxt;
    logic [ROADS-1:0] r_red, r_amber, r_green;
    logic [ROADS-1:0] w_new_red, w_new_amber, w_new_green, w_busy;
    logic             w_road_ok, w_bad, w_conflict, w_timeout;
    logic             w_fault_ev, w_write, w_wdog_en;

    // A zero flash half-period would make the blink timer meaningless
    if (BLINK_HALF < 1) begin : g_blink_half_min
    end

    signal_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .enable  (w_wdog_en),
        .clear   (bus.light_valid),
        .timeout (w_timeout)
    );

    // Would-be lamp vectors after this write, and classification of the write
    always_comb begin
        w_new_red   = r_red;
        w_new_amber = r_amber;
        w_new_green = r_green;
        w_road_ok   = int'(bus.road) < ROADS;
        if (w_road_ok) begin
            w_new_red[bus.road]   = bus.light_out[RED];
            w_new_amber[bus.road] = bus.light_out[AMBER];
            w_new_green[bus.road] = bus.light_out[GREEN];
        end
        // Any road showing green or amber counts as holding right of way
        w_busy     = w_new_green | w_new_amber;
        w_bad      = bus.light_valid && (!is_one_hot(bus.light_out) || !w_road_ok);
        w_conflict = bus.light_valid && !w_bad && (|(w_busy & (w_busy - ROADS'(1))));
    end

    // Next state, fault cause latch and write qualification
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_fault_ev  = 1'b0;
        case (r_state)
            INIT: begin
                if (bus.light_valid && !w_bad && !w_conflict) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_bad) begin
                    w_fault_ev = 1'b1;
                    w_code_nxt = F_BADCODE;
                end else if (w_conflict) begin
                    w_fault_ev = 1'b1;
                    w_code_nxt = F_CONFLICT;
                end else if (w_timeout) begin
                    w_fault_ev = 1'b1;
                    w_code_nxt = F_WDOG;
                end
                if (w_fault_ev) begin
                    w_state_nxt = FAULT;
                end
            end
            FAULT: begin
                if (bus.fault_clear) begin
                    w_state_nxt = INIT;
                    w_code_nxt  = F_NONE;
                end
            end
            default: begin
                w_state_nxt = INIT;
                w_code_nxt  = F_NONE;
            end
        endcase
        w_write   = (r_state != FAULT) && bus.light_valid && !w_bad && !w_conflict && !w_fault_ev;
        w_wdog_en = (r_state == RUN);
    end

    // State and sticky fault cause registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= INIT;
            r_code  <= F_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
        end
    end

`ifdef SIGNAL_HEAD_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] c_blink_last = BW'(BLINK_HALF - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          w_blink_toggle;

    assign w_blink_toggle = (r_blink_cnt == c_blink_last);

    // Flash half-period timer, restarted on every FAULT entry
    always_ff @(posedge clk) begin
        if (!reset || w_fault_ev) begin
            r_blink_cnt <= '0;
        end else if (r_state == FAULT) begin
            r_blink_cnt <= w_blink_toggle ? '0 : r_blink_cnt + BW'(1);
        end
    end
`endif

    // Lamp drive registers: safe pattern in FAULT, otherwise accepted writes
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_red   <= '1;
            r_amber <= '0;
            r_green <= '0;
        end else if (w_fault_ev) begin
            r_green <= '0;
`ifdef SIGNAL_HEAD_BLINK_EN
            r_red   <= '0;
            r_amber <= '1;
`else
            r_red   <= '1;
            r_amber <= '0;
`endif
        end else if (r_state == FAULT) begin
            if (bus.fault_clear) begin
                r_red   <= '1;
                r_amber <= '0;
                r_green <= '0;
            end
`ifdef SIGNAL_HEAD_BLINK_EN
            else if (w_blink_toggle) begin
                r_amber <= ~r_amber;
            end
`endif
        end else if (w_write) begin
            r_red   <= w_new_red;
            r_amber <= w_new_amber;
            r_green <= w_new_green;
        end
    end

    assign bus.lamp_red   = r_red;
    assign bus.lamp_amber = r_amber;
    assign bus.lamp_green = r_green;
    assign bus.fault      = (r_state == FAULT);
    assign bus.fault_code = r_code;

endmodule

`default_nettype wire

// File: tb/tb_signal_head_driver.sv
// ============================================================================
//  Module   : tb_signal_head_driver
//  Purpose  : Self-checking bench for signal_head_driver: directed vector
//             table, watchdog/flash sequence and randomized traffic against a
//             road-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_signal_head_driver;
    localparam int ROADS = 4;
    localparam int WDOG  = 64;
    localparam int BHALF = 8;

`ifdef SIGNAL_HEAD_BLINK_EN
    localparam logic [3:0] FR = 4'h0;
    localparam logic [3:0] FA = 4'hF;
`else
    localparam logic [3:0] FR = 4'hF;
    localparam logic [3:0] FA = 4'h0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    signal_head_driver_if #(.ROADS(ROADS)) bus ();

    signal_head_driver #(
        .ROADS       (ROADS),
        .WDOG_CYCLES (WDOG),
        .BLINK_HALF  (BHALF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model (road-level view) ----------------
    int         m_mode;          // 0 = INIT, 1 = RUN, 2 = FAULT
    logic [2:0] m_lamp [ROADS];  // lamp code per road
    int         m_idle;          // cycles in RUN since the last valid
    int         m_fc;            // cycles spent in FAULT since entry
    logic [1:0] m_code;

    task automatic model_step(input logic rn, input logic v, input logic [1:0] rd,
                              input logic [2:0] lt, input logic clr);
        logic [2:0] tent [ROADS];
        int   busy;
        logic bad, conf;
        logic [1:0] cause;
        if (!rn) begin
            m_mode = 0; m_idle = 0; m_fc = 0; m_code = 2'd0;
            for (int r = 0; r < ROADS; r++) m_lamp[r] = 3'b100;
            return;
        end
        if (m_mode == 2) begin
            if (clr) begin
                m_mode = 0; m_code = 2'd0;
                for (int r = 0; r < ROADS; r++) m_lamp[r] = 3'b100;
            end else begin
                m_fc++;
            end
            return;
        end
        bad = v && (($countones(lt) != 1) || (int'(rd) >= ROADS));
        for (int r = 0; r < ROADS; r++) tent[r] = m_lamp[r];
        if (v && !bad) tent[rd] = lt;
        busy = 0;
        for (int r = 0; r < ROADS; r++) if (tent[r][1] || tent[r][0]) busy++;
        conf  = v && !bad && (busy > 1);
        cause = 2'd0;
        if (m_mode == 1) begin
            if (bad)                cause = 2'd2;
            else if (conf)          cause = 2'd1;
            else if (m_idle >= WDOG) cause = 2'd3;
        end
        if (cause != 2'd0) begin
            m_mode = 2; m_code = cause; m_fc = 0;
        end else if (v && !bad && !conf) begin
            for (int r = 0; r < ROADS; r++) m_lamp[r] = tent[r];
            m_mode = 1; m_idle = 0;
        end else if (m_mode == 1) begin
            m_idle++;
        end
    endtask

    function automatic logic [ROADS-1:0] exp_lamp(input int bitn);
        logic [ROADS-1:0] v;
        v = '0;
        if (m_mode == 2) begin
`ifdef SIGNAL_HEAD_BLINK_EN
            if (bitn == 1 && ((m_fc / BHALF) % 2 == 0)) v = '1;
`else
            if (bitn == 2) v = '1;
`endif
        end else begin
            for (int r = 0; r < ROADS; r++) v[r] = m_lamp[r][bitn];
        end
        return v;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic rn, input logic v, input logic [1:0] rd,
                         input logic [2:0] lt, input logic clr);
        reset           = rn;
        bus.light_valid = v;
        bus.road        = rd;
        bus.light_out   = lt;
        bus.fault_clear = clr;
        model_step(rn, v, rd, lt, clr);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rn, v;
        logic [1:0] rd;
        logic [2:0] lt;
        logic       clr;
        logic [3:0] r, a, g;
        logic       f;
        logic [1:0] c;
    } vec_t;

    vec_t tbl [$];

    initial begin
        // rn v  rd  lt      clr  red    amber  green  f  code
        tbl.push_back('{0, 0, 0, 3'b000, 0, 4'hF, 4'h0, 4'h0, 0, 0});
        tbl.push_back('{0, 0, 0, 3'b000, 0, 4'hF, 4'h0, 4'h0, 0, 0});
        tbl.push_back('{1, 1, 0, 3'b001, 0, 4'hE, 4'h0, 4'h1, 0, 0});
        tbl.push_back('{1, 1, 0, 3'b010, 0, 4'hE, 4'h1, 4'h0, 0, 0});
        tbl.push_back('{1, 1, 0, 3'b100, 0, 4'hF, 4'h0, 4'h0, 0, 0});
        tbl.push_back('{1, 1, 1, 3'b001, 0, 4'hD, 4'h0, 4'h2, 0, 0});
        tbl.push_back('{1, 1, 1, 3'b100, 0, 4'hF, 4'h0, 4'h0, 0, 0});
        tbl.push_back('{1, 1, 0, 3'b001, 0, 4'hE, 4'h0, 4'h1, 0, 0});
        tbl.push_back('{1, 1, 2, 3'b001, 0, FR,   FA,   4'h0, 1, 1}); // two greens
        tbl.push_back('{1, 0, 0, 3'b000, 0, FR,   FA,   4'h0, 1, 1});
        tbl.push_back('{1, 1, 3, 3'b001, 0, FR,   FA,   4'h0, 1, 1}); // ignored in FAULT
        tbl.push_back('{1, 0, 0, 3'b000, 1, 4'hF, 4'h0, 4'h0, 0, 0}); // clear
        tbl.push_back('{1, 1, 0, 3'b011, 0, 4'hF, 4'h0, 4'h0, 0, 0}); // bad code in INIT
        tbl.push_back('{1, 1, 0, 3'b001, 0, 4'hE, 4'h0, 4'h1, 0, 0});
        tbl.push_back('{1, 1, 1, 3'b011, 0, FR,   FA,   4'h0, 1, 2}); // bad over conflict
        tbl.push_back('{1, 1, 1, 3'b000, 0, FR,   FA,   4'h0, 1, 2});
        tbl.push_back('{1, 0, 0, 3'b000, 1, 4'hF, 4'h0, 4'h0, 0, 0});
        tbl.push_back('{1, 0, 0, 3'b000, 1, 4'hF, 4'h0, 4'h0, 0, 0}); // clear in INIT
        tbl.push_back('{1, 1, 3, 3'b100, 0, 4'hF, 4'h0, 4'h0, 0, 0});
        tbl.push_back('{1, 1, 3, 3'b000, 0, FR,   FA,   4'h0, 1, 2}); // zero code
        tbl.push_back('{0, 0, 0, 3'b000, 0, 4'hF, 4'h0, 4'h0, 0, 0}); // reset in FAULT
        tbl.push_back('{1, 1, 2, 3'b010, 0, 4'hB, 4'h4, 4'h0, 0, 0});
        tbl.push_back('{1, 1, 1, 3'b010, 0, FR,   FA,   4'h0, 1, 1}); // two ambers
        tbl.push_back('{1, 1, 2, 3'b101, 1, 4'hF, 4'h0, 4'h0, 0, 0}); // clear wins
        tbl.push_back('{0, 0, 0, 3'b000, 0, 4'hF, 4'h0, 4'h0, 0, 0});

        // Directed vector table
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].rn, tbl[i].v, tbl[i].rd, tbl[i].lt, tbl[i].clr);
            check($sformatf("vec%0d red", i),   32'(bus.lamp_red),   32'(tbl[i].r));
            check($sformatf("vec%0d amber", i), 32'(bus.lamp_amber), 32'(tbl[i].a));
            check($sformatf("vec%0d green", i), 32'(bus.lamp_green), 32'(tbl[i].g));
            check($sformatf("vec%0d fault", i), 32'(bus.fault),      32'(tbl[i].f));
            check($sformatf("vec%0d code", i),  32'(bus.fault_code), 32'(tbl[i].c));
        end

        // Watchdog cleared by traffic: valid every 60 cycles never times out
        cycle(1, 1, 0, 3'b001, 0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 60; i++) cycle(1, 0, 0, 3'b000, 0);
            cycle(1, 1, 0, (k % 2 == 0) ? 3'b010 : 3'b001, 0);
        end
        check("wdog_kept_alive fault", 32'(bus.fault), 32'd0);

        // Watchdog timeout: 64 idle cycles still fine, the 65th faults
        cycle(0, 0, 0, 3'b000, 0);
        cycle(1, 1, 0, 3'b001, 0);
        for (int i = 0; i < WDOG; i++) cycle(1, 0, 0, 3'b000, 0);
        check("wdog_64 fault", 32'(bus.fault), 32'd0);
        cycle(1, 0, 0, 3'b000, 0);
        check("wdog_65 fault", 32'(bus.fault),      32'd1);
        check("wdog_65 code",  32'(bus.fault_code), 32'd3);
        check("wdog_65 green", 32'(bus.lamp_green), 32'd0);
        check("wdog_65 red",   32'(bus.lamp_red),   32'(FR));
        check("wdog_65 amber", 32'(bus.lamp_amber), 32'(FA));
        // Fault pattern over time: flash period from entry, or steady red
        for (int k = 1; k <= 20; k++) begin
            cycle(1, 0, 0, 3'b000, 0);
`ifdef SIGNAL_HEAD_BLINK_EN
            check($sformatf("flash%0d amber", k), 32'(bus.lamp_amber),
                  ((k / BHALF) % 2 == 0) ? 32'hF : 32'h0);
            check($sformatf("flash%0d red", k), 32'(bus.lamp_red), 32'h0);
`else
            check($sformatf("steady%0d amber", k), 32'(bus.lamp_amber), 32'h0);
            check($sformatf("steady%0d red", k), 32'(bus.lamp_red), 32'hF);
`endif
            check($sformatf("hold%0d code", k), 32'(bus.fault_code), 32'd3);
        end
        cycle(1, 0, 0, 3'b000, 1);
        check("wdog_clear fault", 32'(bus.fault),      32'd0);
        check("wdog_clear code",  32'(bus.fault_code), 32'd0);
        check("wdog_clear red",   32'(bus.lamp_red),   32'hF);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic       rn, v, clr;
            logic [1:0] rd;
            logic [2:0] lt;
            int         sel;
            rn  = ($urandom_range(0, 199) != 0);
            v   = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 7) == 0);
            rd  = 2'($urandom_range(0, ROADS - 1));
            sel = $urandom_range(0, 9);
            lt  = (sel < 9) ? 3'(1 << (sel % 3)) : 3'($urandom_range(0, 7));
            cycle(rn, v, rd, lt, clr);
            check("rand red",   32'(bus.lamp_red),   32'(exp_lamp(2)));
            check("rand amber", 32'(bus.lamp_amber), 32'(exp_lamp(1)));
            check("rand green", 32'(bus.lamp_green), 32'(exp_lamp(0)));
            check("rand fault", 32'(bus.fault),      (m_mode == 2) ? 32'd1 : 32'd0);
            check("rand code",  32'(bus.fault_code), 32'(m_code));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
